// File: rtl/ks_seq_pkg.sv
// Shared definitions for the PRESENT-80 key-schedule sequencer.
package ks_seq_pkg;

    localparam int KEY_W = 80;
    localparam int RK_W  = 64;
    localparam int NRK   = 32;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ks_seq_kr.sv
// One PRESENT-80 key-round update: rotate left 61, S-box on the top nibble,
// XOR the round counter into bits [60:64] (bit 0 is the MSB throughout).
module kr
    import ks_seq_pkg::*;
(
    input  logic [0:KEY_W-1] kinp,
    input  logic [CNT_W-1:0] cnt,
    output logic [0:KEY_W-1] kout
);

    logic [0:KEY_W-1] w_rot;
    logic [0:3]       w_sb;

    assign w_rot = {kinp[61:KEY_W-1], kinp[0:60]};

    // PRESENT S-box applied to the leading nibble of the rotated key
    always_comb begin
        w_sb = 4'hC;
        case (w_rot[0:3])
            4'h0: w_sb = 4'hC;
            4'h1: w_sb = 4'h5;
            4'h2: w_sb = 4'h6;
            4'h3: w_sb = 4'hB;
            4'h4: w_sb = 4'h9;
            4'h5: w_sb = 4'h0;
            4'h6: w_sb = 4'hA;
            4'h7: w_sb = 4'hD;
            4'h8: w_sb = 4'h3;
            4'h9: w_sb = 4'hE;
            4'hA: w_sb = 4'hF;
            4'hB: w_sb = 4'h8;
            4'hC: w_sb = 4'h4;
            4'hD: w_sb = 4'h7;
            4'hE: w_sb = 4'h1;
            4'hF: w_sb = 4'h2;
            default: w_sb = 4'hC;
        endcase
    end

    // Assemble the updated key: substituted nibble and counter injection
    always_comb begin
        kout         = w_rot;
        kout[0:3]    = w_sb;
        kout[60:64]  = w_rot[60:64] ^ cnt;
    end

endmodule

// File: rtl/ks_seq.sv
// Round-key sequencer: loads an 80-bit master key and streams NRK round keys
// over a valid/ready handshake, one per cycle while the consumer is ready.
module ks_seq
    import ks_seq_pkg::KEY_W, ks_seq_pkg::CNT_W, ks_seq_pkg::state_t;
    import ks_seq_pkg::IDLE, ks_seq_pkg::RUN, ks_seq_pkg::DONE;
#(
    parameter int NRK = ks_seq_pkg::NRK,
    parameter int RKW = ks_seq_pkg::RK_W
)(
    input  logic             clk,
    input  logic             rstn,
    input  logic [0:KEY_W-1] key_in,
    input  logic             start,
    input  logic             abort,
    input  logic             rk_ready,
    output logic [0:RKW-1]   rk,
    output logic [0:4]       rk_idx,
    output logic             rk_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NRK - 1);

    state_t           r_state;
    logic [0:KEY_W-1] r_key;
    logic [CNT_W-1:0] r_idx;

    logic [CNT_W-1:0] w_cnt;
    logic [0:KEY_W-1] w_next_key;
    logic             w_xfer;

    assign w_cnt  = r_idx + 5'd1;
    assign w_xfer = (r_state == RUN) && rk_ready;

    kr u_kr (
        .kinp (r_key),
        .cnt  (w_cnt),
        .kout (w_next_key)
    );

    // Sequencer state, key register and index; abort overrides any transfer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_key   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        r_key   <= key_in;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (w_xfer) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= DONE;
                        end else begin
                            r_key <= w_next_key;
                            r_idx <= w_cnt;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rk       = r_key[0:RKW-1];
    assign rk_idx   = r_idx;
    assign rk_valid = (r_state == RUN);
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);

endmodule

// File: tb/tb_ks_seq.sv
// Self-checking bench for ks_seq against a PRESENT-80 key-schedule model.
module tb_ks_seq;

    localparam int NRK = 32;

    logic        clk = 1'b0;
    logic        rstn;
    logic [79:0] key_in;
    logic        start;
    logic        abort;
    logic        rk_ready;
    logic [63:0] rk;
    logic [4:0]  rk_idx;
    logic        rk_valid;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] exp_rk [NRK];
    logic [63:0] got_rk [NRK];
    logic [3:0]  SBOX   [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    ks_seq #(.NRK(32), .RKW(64)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .key_in   (key_in),
        .start    (start),
        .abort    (abort),
        .rk_ready (rk_ready),
        .rk       (rk),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [79:0] rand_key();
        return {$urandom, $urandom, 16'($urandom)};
    endfunction

    // Textbook PRESENT-80 key schedule on a [79:0] register
    task automatic model_sched(input logic [79:0] key);
        logic [79:0] k = key;
        for (int i = 1; i <= NRK; i++) begin
            exp_rk[i-1] = k[79:16];
            k = {k[18:0], k[79:19]};
            k[79:76] = SBOX[k[79:76]];
            k[19:15] = k[19:15] ^ 5'(i);
        end
    endtask

    // PRESENT-80 encryption using the round keys captured from the DUT
    function automatic logic [63:0] present_enc(input logic [63:0] pt);
        logic [63:0] s = pt;
        logic [63:0] t;
        for (int r = 0; r < 31; r++) begin
            s = s ^ got_rk[r];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = SBOX[s[4*n +: 4]];
            t = '0;
            for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : ((16 * b) % 63)] = s[b];
            s = t;
        end
        return s ^ got_rk[31];
    endfunction

    // Full schedule with optional ready stalls and spurious start/key activity
    task automatic run_sched(input logic [79:0] key, input int stall_pct,
                             input bit noise, input string tag);
        int          exp_idx = 0;
        bit          prev_stall = 1'b0;
        bit          fin = 1'b0;
        logic [63:0] prev_rk = '0;
        logic [4:0]  prev_idx = '0;
        model_sched(key);
        @(negedge clk);
        key_in = key; start = 1'b1; abort = 1'b0; rk_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (rk_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s_latency rk_valid=%b expected 1", tag, rk_valid);
        end
        for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
            if (exp_idx < NRK) begin
                n_vec++;
                if (rk_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
                    rk_idx !== 5'(exp_idx) || rk !== exp_rk[exp_idx]) begin
                    n_err++;
                    $display("FAIL %s_key v=%b b=%b d=%b idx=%0d rk=%h expected v=1 b=1 d=0 idx=%0d rk=%h",
                             tag, rk_valid, busy, done, rk_idx, rk, exp_idx, exp_rk[exp_idx]);
                end
                if (prev_stall) begin
                    n_vec++;
                    if (rk !== prev_rk || rk_idx !== prev_idx) begin
                        n_err++;
                        $display("FAIL %s_stall_hold idx=%0d rk=%h expected idx=%0d rk=%h",
                                 tag, rk_idx, rk, prev_idx, prev_rk);
                    end
                end
                got_rk[exp_idx] = rk;
                prev_rk  = rk;
                prev_idx = rk_idx;
                rk_ready = ($urandom_range(99) >= stall_pct);
                prev_stall = !rk_ready;
                if (noise) begin
                    start  = 1'($urandom_range(1));
                    key_in = rand_key();
                end
                if (rk_ready) exp_idx++;
                @(negedge clk);
            end else begin
                n_vec++;
                if (done !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s_done d=%b v=%b b=%b expected d=1 v=0 b=1",
                             tag, done, rk_valid, busy);
                end
                if (stall_pct == 0) begin
                    n_vec++;
                    if (cyc != NRK) begin
                        n_err++;
                        $display("FAIL %s_done_time cycles=%0d expected %0d", tag, cyc, NRK);
                    end
                end
                if (noise) begin
                    start  = 1'b1;
                    key_in = rand_key();
                end
                @(negedge clk);
                start = 1'b0;
                n_vec++;
                if (done !== 1'b0 || busy !== 1'b0 || rk_valid !== 1'b0 ||
                    rk_idx !== 5'(NRK - 1) || rk !== exp_rk[NRK-1]) begin
                    n_err++;
                    $display("FAIL %s_idle d=%b b=%b v=%b idx=%0d rk=%h expected d=0 b=0 v=0 idx=%0d rk=%h",
                             tag, done, busy, rk_valid, rk_idx, rk, NRK - 1, exp_rk[NRK-1]);
                end
                fin = 1'b1;
            end
        end
        if (!fin) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout transfers=%0d expected %0d", tag, exp_idx, NRK);
        end
        rk_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; abort = 1'b0; rk_ready = 1'b0; key_in = '0;
        repeat (2) @(negedge clk);
        start = 1'b1; key_in = rand_key();
        @(negedge clk);
        n_vec++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            rk_idx !== 5'd0 || rk !== 64'd0) begin
            n_err++;
            $display("FAIL reset_state v=%b b=%b d=%b idx=%0d rk=%h expected all zero",
                     rk_valid, busy, done, rk_idx, rk);
        end
        start = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || rk_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release b=%b v=%b expected 0 0", busy, rk_valid);
        end
    endtask

    task automatic test_zero_key();
        logic [63:0] ct;
        run_sched(80'd0, 0, 1'b0, "zero");
        n_vec++;
        if (got_rk[0] !== 64'h0000000000000000 || got_rk[1] !== 64'hC000000000000000 ||
            got_rk[2] !== 64'h5000180000000001) begin
            n_err++;
            $display("FAIL zero_first3 got %h %h %h expected 0000000000000000 C000000000000000 5000180000000001",
                     got_rk[0], got_rk[1], got_rk[2]);
        end
        ct = present_enc(64'd0);
        n_vec++;
        if (ct !== 64'h5579C1387B228445) begin
            n_err++;
            $display("FAIL zero_encrypt ct=%h expected 5579c1387b228445", ct);
        end
    endtask

    task automatic test_random_keys();
        for (int i = 0; i < 3; i++) run_sched(rand_key(), 0, 1'b0, "rand");
    endtask

    task automatic test_stall();
        logic [79:0] key = rand_key();
        logic [63:0] ref_rk [NRK];
        run_sched(key, 0, 1'b0, "nostall");
        for (int i = 0; i < NRK; i++) ref_rk[i] = got_rk[i];
        run_sched(key, 50, 1'b0, "stall");
        for (int i = 0; i < NRK; i++) begin
            n_vec++;
            if (got_rk[i] !== ref_rk[i]) begin
                n_err++;
                $display("FAIL stall_vs_nostall idx=%0d got=%h expected %h", i, got_rk[i], ref_rk[i]);
            end
        end
    endtask

    task automatic test_abort();
        logic [79:0] key = rand_key();
        bit hit = 1'b0;
        bit saw_done = 1'b0;
        model_sched(key);
        @(negedge clk);
        key_in = key; start = 1'b1; abort = 1'b0; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 50 && !hit; cyc++) begin
            if (rk_valid === 1'b1 && rk_idx === 5'd10) begin
                n_vec++;
                if (rk !== exp_rk[10]) begin
                    n_err++;
                    $display("FAIL abort_pre rk=%h expected %h", rk, exp_rk[10]);
                end
                abort = 1'b1; rk_ready = 1'b1; start = 1'b1;
                hit = 1'b1;
            end
            @(negedge clk);
        end
        abort = 1'b0; start = 1'b0; rk_ready = 1'b0;
        n_vec++;
        if (!hit || rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rk_idx !== 5'd10) begin
            n_err++;
            $display("FAIL abort_idle hit=%b v=%b b=%b d=%b idx=%0d expected hit=1 v=0 b=0 d=0 idx=10",
                     hit, rk_valid, busy, done, rk_idx);
        end
        repeat (40) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        n_vec++;
        if (saw_done) begin
            n_err++;
            $display("FAIL abort_no_done saw_done=1 expected 0");
        end
        run_sched(rand_key(), 0, 1'b0, "after_abort");
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        @(negedge clk);
        key_in = rand_key(); start = 1'b1; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 50 && !hit; cyc++) begin
            if (rk_valid === 1'b1 && rk_idx === 5'd5) hit = 1'b1;
            else @(negedge clk);
        end
        #2 rstn = 1'b0;
        #1;
        n_vec++;
        if (!hit || rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            rk_idx !== 5'd0 || rk !== 64'd0) begin
            n_err++;
            $display("FAIL reset_async hit=%b v=%b b=%b d=%b idx=%0d rk=%h expected hit=1 and all zero",
                     hit, rk_valid, busy, done, rk_idx, rk);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || rk_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_release b=%b v=%b expected 0 0", busy, rk_valid);
        end
        rk_ready = 1'b0;
    endtask

    task automatic test_start_ignored();
        run_sched(rand_key(), 0, 1'b1, "noise");
        run_sched(rand_key(), 30, 1'b1, "noise_stall");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_key();
        test_random_keys();
        test_stall();
        test_abort();
        test_reset_mid();
        test_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
